// File: rtl/ifu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_pkg                                                              |
// | Shared types and helpers for the instruction fetch unit.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ifu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    // Pointer width for an n-entry ring; at least one bit so a 1-deep ring still has a pointer.
    function automatic int ptr_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_fifo                                                             |
// | Synchronous show-ahead FIFO with clear; head is valid when !empty.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic                          full,
    output logic                          empty,
    output logic [ptr_width(DEPTH):0]     count
);

    localparam int            PW       = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = pop & (r_count != '0);
    assign w_do_push = push & ((r_count != FULL_CNT) | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_buffer                                                        |
// | Fetch stage: issues PCs to imem, queues {pc,inst} for decode, and    |
// | discards wrong-path responses after a redirect. Revision: 1.0        |
// +----------------------------------------------------------------------+
module ifetch_buffer
    import ifu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_valid,
    input  logic [XLEN-1:0] pc,
    output logic            pc_ready,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int PEND_W = ptr_width(MAX_OUT);
    localparam int FIFO_W = ptr_width(DEPTH);

    logic [PEND_W:0]   w_pend_cnt;
    logic [PEND_W:0]   r_drop_cnt;
    logic [FIFO_W:0]   w_fifo_cnt;
    logic [XLEN-1:0]   w_pend_head;
    logic              w_pend_empty;
    logic              w_pend_full;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic              w_resp_live;
    logic [31:0]       w_inflight;
    logic [31:0]       w_reserved;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;
    logic              w_unused;

    assign w_inflight = 32'(w_pend_cnt) + 32'(r_drop_cnt);
    assign w_reserved = 32'(w_fifo_cnt) + 32'(w_pend_cnt);

    // Every live request owns an ififo slot, so a response can always be accepted.
    assign imem_req_valid = ~rst & pc_valid & ~flush
                          & (w_inflight < 32'(MAX_OUT))
                          & (w_reserved < 32'(DEPTH));
    assign imem_req_addr  = pc;
    assign pc_ready       = imem_req_valid & imem_req_ready;

    assign w_resp_live  = imem_resp_valid & (r_drop_cnt == '0) & ~w_pend_empty;
    assign w_push_entry = '{pc: w_pend_head, data: imem_resp_data};

    ifu_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_pend (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (pc_ready),
        .push_data (pc),
        .pop       (w_resp_live),
        .head      (w_pend_head),
        .full      (w_pend_full),
        .empty     (w_pend_empty),
        .count     (w_pend_cnt)
    );

    ifu_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_ififo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (w_resp_live),
        .push_data (w_push_entry),
        .pop       (inst_valid & inst_ready),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_cnt)
    );

    // On redirect every outstanding response becomes stale, minus one arriving right now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (flush) begin
            if (imem_resp_valid && (w_inflight != 32'd0)) begin
                r_drop_cnt <= (PEND_W + 1)'(w_inflight - 32'd1);
            end else begin
                r_drop_cnt <= (PEND_W + 1)'(w_inflight);
            end
        end else if (imem_resp_valid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

    assign inst_valid = ~w_fifo_empty;
    assign inst_pc    = w_head.pc;
    assign inst_data  = w_head.data;

    assign w_unused = &{1'b0, w_pend_full, w_fifo_full};

endmodule
`default_nettype wire

// File: tb/tb_ifetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifetch_buffer                                                     |
// | Scoreboard bench: memory model, PC generator and decode checker.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ifetch_buffer;
    import ifu_pkg::*;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_rsp_t;

    logic        clk;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc;
    logic        pc_ready;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int           n_checks;
    int           n_errors;
    int           cyc;
    int           lat;
    int           n_hs;
    int           n_cons;
    int           base;
    logic [31:0]  pc_gen;
    mem_rsp_t     mem_q[$];
    fetch_entry_t sb[$];

    ifetch_buffer #(.DEPTH(4), .MAX_OUT(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_valid        (pc_valid),
        .pc              (pc),
        .pc_ready        (pc_ready),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    // Memory, PC generator and decode side: drive at negedge, sample 1ns before posedge.
    always begin
        logic [31:0]  d;
        fetch_entry_t e;
        @(negedge clk);
        cyc++;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #4;
        if (rst || flush) begin
            sb.delete();
        end else if (inst_valid && inst_ready) begin
            n_cons++;
            check("deliver_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("inst_pc", 64'(inst_pc), 64'(e.pc));
                check("inst_data", 64'(inst_data), 64'(e.data));
            end
        end
        if (!rst && imem_req_valid && imem_req_ready) begin
            n_hs++;
            d = mkdata(imem_req_addr);
            mem_q.push_back('{due: cyc + lat, data: d});
            if (!flush) sb.push_back('{pc: imem_req_addr, data: d});
            pc_gen = imem_req_addr + 32'd4;
        end
        @(posedge clk);
        #1;
        pc = pc_gen;
    end

    task automatic idle(input int n);
        pc_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_first_pc(input logic [31:0] exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (inst_valid) begin
                check("first_pc_after_flush", 64'(inst_pc), 64'(exp));
                seen = 1'b1;
            end
        end
        check("first_pc_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; n_hs = 0; n_cons = 0;
        rst = 1'b1; pc_valid = 1'b1; flush = 1'b0; imem_req_ready = 1'b1;
        inst_ready = 1'b0; lat = 1; pc_gen = '0; pc = '0;
        imem_resp_valid = 1'b0; imem_resp_data = '0;

        repeat (3) @(negedge clk);
        #2;
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_pc", 64'(inst_pc), 64'd0);
        check("rst_inst_data", 64'(inst_data), 64'd0);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_pc_ready", 64'(pc_ready), 64'd0);

        // Streaming with a 1-cycle memory
        @(negedge clk);
        rst = 1'b0; inst_ready = 1'b1;
        base = n_hs;
        repeat (2) @(negedge clk);
        check("stream_first_issues", 64'(n_hs - base), 64'd2);
        base = n_cons;
        repeat (20) @(negedge clk);
        check("stream_no_gaps", 64'(n_cons - base), 64'd20);
        idle(6);

        // Backpressure from decode
        inst_ready = 1'b0; pc_gen = 32'h200;
        idle(2);
        pc_valid = 1'b1;
        base = n_hs;
        repeat (10) @(negedge clk);
        check("bp_accepted", 64'(n_hs - base), 64'd4);
        inst_ready = 1'b1;
        #2;
        check("bp_pc_ready_low", 64'(pc_ready), 64'd0);
        @(negedge clk);
        inst_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_one_more", 64'(n_hs - base), 64'd5);
        inst_ready = 1'b1;
        idle(8);

        // Memory stall
        imem_req_ready = 1'b0; pc_gen = 32'h400;
        idle(2);
        pc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("stall_pc_ready", 64'(pc_ready), 64'd0);
            check("stall_addr", 64'(imem_req_addr), 64'h400);
            check("stall_inst_valid", 64'(inst_valid), 64'd0);
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        #2;
        check("stall_resume", 64'(pc_ready), 64'd1);
        idle(8);

        // Flush with two requests in flight, 3-cycle memory
        lat = 3; pc_gen = 32'h10;
        idle(2);
        pc_valid = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b1; pc_gen = 32'h100;
        #2;
        check("flush_no_issue", 64'(imem_req_valid), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        expect_first_pc(32'h100);
        idle(12);

        // Flush coinciding with a response, 2-cycle memory
        lat = 2; pc_gen = 32'h20;
        idle(2);
        pc_valid = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b1; pc_gen = 32'h300;
        #2;
        check("coincide_resp_in_flush", 64'(imem_resp_valid), 64'd1);
        check("coincide_no_issue", 64'(imem_req_valid), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #2;
        check("coincide_reissue", 64'(pc_ready), 64'd1);
        expect_first_pc(32'h300);
        idle(10);

        // Async reset mid-stream with cnt=3 and one response still due
        inst_ready = 1'b0; pc_gen = 32'h500;
        idle(2);
        pc_valid = 1'b1;
        repeat (6) @(negedge clk);
        pc_valid = 1'b0;
        #1;
        check("pre_rst_inst_valid", 64'(inst_valid), 64'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("async_rst_inst_valid", 64'(inst_valid), 64'd0);
        check("async_rst_inst_pc", 64'(inst_pc), 64'd0);
        #1;
        rst = 1'b0;
        inst_ready = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        check("late_resp_ignored", 64'(inst_valid), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
